// File: rtl/car_motion_unit.sv
// car_motion_unit: timed elevator car responder. Tracks floor, door and
// motion state in response to updown / door_open commands, with a
// door/motion interlock and shaft-limit rejection. All outputs registered.
module car_motion_unit #(
  parameter int NUM_FLOORS       = 8,
  parameter int INIT_FLOOR       = 0,
  parameter int TRAVEL_CYCLES    = 10,
  parameter int DOOR_MOVE_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] updown_i,
  input  logic       door_open_i,
  output logic [2:0] floor_o,
  output logic       door_o,
  output logic       moving_o,
  output logic       dir_up_o,
  output logic       limit_err_o
);

  localparam int MAXC = (TRAVEL_CYCLES > DOOR_MOVE_CYCLES) ? TRAVEL_CYCLES : DOOR_MOVE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [2:0]    TOP_FLOOR = 3'(NUM_FLOORS - 1);
  localparam logic [2:0]    RST_FLOOR = 3'(INIT_FLOOR);
  localparam logic [CW-1:0] TRV_LAST  = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_MOVE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVING  = 3'd1,
    OPENING = 3'd2,
    OPEN    = 3'd3,
    CLOSING = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    floor_q, floor_d;
  logic          dir_q, dir_d;
  logic          lerr_q, lerr_d;
  logic          door_q, door_d;
  logic          moving_q, moving_d;

  logic up_cmd, dn_cmd, cont, at_lim;

  // 11 decodes as neither up nor down, i.e. stop
  assign up_cmd = (updown_i == 2'b01);
  assign dn_cmd = (updown_i == 2'b10);

  // State and datapath registers; reset aborts any segment or door cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      floor_q  <= RST_FLOOR;
      dir_q    <= 1'b1;
      lerr_q   <= 1'b0;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      lerr_q   <= lerr_d;
      door_q   <= door_d;
      moving_q <= moving_d;
    end
  end

  // Next-state: transitions, shared counter, floor stepping, limit checks
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    lerr_d  = 1'b0;
    cont    = 1'b0;
    at_lim  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // door request wins over a simultaneous motion command
        if (door_open_i) begin
          state_d = OPENING;
          cnt_d   = '0;
        end else if (up_cmd) begin
          if (floor_q < TOP_FLOOR) begin
            state_d = MOVING;
            dir_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            lerr_d = 1'b1;
          end
        end else if (dn_cmd) begin
          if (floor_q != 3'd0) begin
            state_d = MOVING;
            dir_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            lerr_d = 1'b1;
          end
        end
      end
      MOVING: begin
        // segment always completes; commands only re-sampled on arrival
        if (cnt_q == TRV_LAST) begin
          cnt_d   = '0;
          floor_d = dir_q ? floor_q + 3'd1 : floor_q - 3'd1;
          cont    = dir_q ? up_cmd : dn_cmd;
          at_lim  = dir_q ? (floor_d == TOP_FLOOR) : (floor_d == 3'd0);
          if (!(cont && !at_lim)) state_d = IDLE;
          lerr_d  = cont && at_lim;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OPENING: begin
        if (cnt_q == DOOR_LAST) begin
          state_d = OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OPEN: begin
        if (!door_open_i) begin
          state_d = CLOSING;
          cnt_d   = '0;
        end
      end
      CLOSING: begin
        // reopen takes priority even on the final closing cycle
        if (door_open_i) begin
          state_d = OPEN;
          cnt_d   = '0;
        end else if (cnt_q == DOOR_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs derived from the next state so they register alongside it
  always_comb begin
    door_d   = (state_d == OPEN) || (state_d == CLOSING);
    moving_d = (state_d == MOVING);
  end

  assign floor_o     = floor_q;
  assign door_o      = door_q;
  assign moving_o    = moving_q;
  assign dir_up_o    = dir_q;
  assign limit_err_o = lerr_q;

endmodule
